// File: rtl/cache_read_arbiter_if.sv
// Bundle of client request/response handshakes and the cache read port.
// master: clients plus cache side; slave: the arbiter.
interface cache_read_arbiter_if #(
    parameter int unsigned NUM_REQUESTERS  = 2,
`ifdef FORMAL
    parameter int unsigned C_DATA_WIDTH    = 8,
    parameter int unsigned C_SIZE_OF_CACHE = 4
`else
    parameter int unsigned C_DATA_WIDTH    = 128,
    parameter int unsigned C_SIZE_OF_CACHE = 64
`endif
);
    localparam int unsigned AW = $clog2(C_SIZE_OF_CACHE);

    logic [NUM_REQUESTERS-1:0]    req_valid;
    logic [NUM_REQUESTERS*AW-1:0] req_addr;
    logic [NUM_REQUESTERS-1:0]    req_ready;
    logic [NUM_REQUESTERS-1:0]    rsp_valid;
    logic [C_DATA_WIDTH-1:0]      rsp_data;
    logic [NUM_REQUESTERS-1:0]    rsp_ready;
    logic [AW-1:0]                cache_addr;
    logic                         cache_empty;
    logic [C_DATA_WIDTH-1:0]      cache_data;
    logic                         cache_data_valid;

    modport master (
        output req_valid, req_addr, rsp_ready, cache_empty, cache_data, cache_data_valid,
        input  req_ready, rsp_valid, rsp_data, cache_addr
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, cache_empty, cache_data, cache_data_valid,
        output req_ready, rsp_valid, rsp_data, cache_addr
    );
endinterface

// File: rtl/cache_read_arbiter.sv
// Round-robin arbiter sharing the cache read port among NUM_REQUESTERS clients;
// one outstanding read at a time, data returned over a per-client handshake.
module cache_read_arbiter #(
    parameter int unsigned NUM_REQUESTERS  = 2,
`ifdef FORMAL
    parameter int unsigned C_DATA_WIDTH    = 8,
    parameter int unsigned C_SIZE_OF_CACHE = 4
`else
    parameter int unsigned C_DATA_WIDTH    = 128,
    parameter int unsigned C_SIZE_OF_CACHE = 64
`endif
) (
    input logic                  clk,
    input logic                  reset,
    cache_read_arbiter_if.slave  bus
);
    localparam int unsigned AW = $clog2(C_SIZE_OF_CACHE);
    localparam int unsigned GW = $clog2(NUM_REQUESTERS);

    typedef enum logic [1:0] {StIdle, StRead, StCapt, StResp} state_e;

    state_e                    state_q, state_d;
    logic [GW-1:0]             grant_q, grant_d;
    logic [GW-1:0]             last_q, last_d;
    logic [AW-1:0]             cache_addr_q, cache_addr_d;
    logic [C_DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [NUM_REQUESTERS-1:0] rsp_valid_q, rsp_valid_d;
    logic [NUM_REQUESTERS-1:0] req_ready;
    logic [GW-1:0]             winner;
    logic                      win_found;
    logic                      handshake;
    int unsigned               cand;

    // First requesting client searching last+1, last+2, ... modulo N.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_REQUESTERS; k++) begin
            cand = 32'(last_q) + k;
            if (cand >= NUM_REQUESTERS) begin
                cand = cand - NUM_REQUESTERS;
            end
            if (!win_found && bus.req_valid[GW'(cand)]) begin
                winner    = GW'(cand);
                win_found = 1'b1;
            end
        end
    end

    assign handshake = (state_q == StIdle) && !bus.cache_empty && win_found;

    always_comb begin
        req_ready = '0;
        if (handshake && reset) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cache_addr_d = cache_addr_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            StIdle: begin
                if (handshake) begin
                    cache_addr_d = bus.req_addr[32'(winner) * AW +: AW];
                    grant_d      = winner;
                    state_d      = StRead;
                end
            end
            StRead: begin
                // The cache ignores the address while empty, so retry the sample.
                if (!bus.cache_empty) begin
                    state_d = StCapt;
                end
            end
            StCapt: begin
                if (bus.cache_data_valid) begin
                    rsp_data_d           = bus.cache_data;
                    rsp_valid_d          = '0;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready[grant_q]) begin
                    rsp_valid_d = '0;
                    last_d      = grant_q;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_q       <= GW'(NUM_REQUESTERS - 1);
            cache_addr_q <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            cache_addr_q <= cache_addr_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.cache_addr = cache_addr_q;

endmodule

// File: tb/tb_cache_read_arbiter.sv
// Bench for cache_read_arbiter: directed scenarios then random traffic, all checked
// each cycle against a transaction-level model of arbitration and response timing.
module tb_cache_read_arbiter;
    localparam int N     = 2;
    localparam int DW    = 128;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_read_arbiter_if #(.NUM_REQUESTERS(N), .C_DATA_WIDTH(DW), .C_SIZE_OF_CACHE(DEPTH)) bus ();

    cache_read_arbiter #(.NUM_REQUESTERS(N), .C_DATA_WIDTH(DW), .C_SIZE_OF_CACHE(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Cache stand-in: registered read, address ignored while empty.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] cache_q;
    always @(posedge clk) if (!bus.cache_empty) cache_q <= mem[bus.cache_addr];
    assign bus.cache_data = cache_q;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: one outstanding transaction and its progress milestones.
    bit            m_out;
    int            m_client;
    int            m_stage;  // 0 waiting cache sample, 1 waiting data, 2 response shown
    int            m_last;
    logic [AW-1:0] m_caddr;
    logic [DW-1:0] m_data;
    logic [N-1:0]  prev_rv;

    int            hs_cyc_q[$];
    int            hs_cli_q[$];
    int            rise_cyc_q[$];
    logic [DW-1:0] rise_data_q[$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [DW-1:0] qgetd(input logic [DW-1:0] q[$], input int i);
        return (i < q.size()) ? q[i] : '1;
    endfunction

    task automatic model_reset();
        m_out    = 1'b0;
        m_client = 0;
        m_stage  = 0;
        m_last   = N - 1;
        m_caddr  = '0;
        m_data   = '0;
        prev_rv  = '0;
    endtask

    task automatic clear_logs();
        hs_cyc_q.delete();
        hs_cli_q.delete();
        rise_cyc_q.delete();
        rise_data_q.delete();
    endtask

    // Called mid-cycle with inputs driven; checks, advances the model, moves one cycle on.
    task automatic step();
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rv;
        int w;
        #1;
        w = rr_pick(bus.req_valid, m_last);
        exp_ready = '0;
        if (!m_out && !bus.cache_empty && w >= 0) exp_ready[w] = 1'b1;
        exp_rv = '0;
        if (m_out && m_stage == 2) exp_rv[m_client] = 1'b1;
        chk("req_ready", DW'(bus.req_ready), DW'(exp_ready));
        chk("rsp_valid", DW'(bus.rsp_valid), DW'(exp_rv));
        chk("cache_addr", DW'(bus.cache_addr), DW'(m_caddr));
        if (m_out && m_stage == 2) chk("rsp_data", bus.rsp_data, m_data);

        if (bus.req_ready != '0) begin
            hs_cyc_q.push_back(cyc);
            hs_cli_q.push_back($clog2(bus.req_ready));
        end
        if (bus.rsp_valid != '0 && prev_rv == '0) begin
            rise_cyc_q.push_back(cyc);
            rise_data_q.push_back(bus.rsp_data);
        end
        prev_rv = bus.rsp_valid;

        if (!m_out) begin
            if (w >= 0 && !bus.cache_empty) begin
                m_out    = 1'b1;
                m_client = w;
                m_caddr  = bus.req_addr[w*AW +: AW];
                m_data   = mem[m_caddr];
                m_stage  = 0;
            end
        end else if (m_stage == 0) begin
            if (!bus.cache_empty) m_stage = 1;
        end else if (m_stage == 1) begin
            if (bus.cache_data_valid) m_stage = 2;
        end else if (bus.rsp_ready[m_client]) begin
            m_out  = 1'b0;
            m_last = m_client;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_addrs(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.req_addr = {a1, a0};
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(32'hA0 + i);
        reset                = 1'b0;
        bus.req_valid        = '1;
        bus.req_addr         = '0;
        bus.rsp_ready        = '0;
        bus.cache_empty      = 1'b0;
        bus.cache_data_valid = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", DW'(bus.req_ready), '0);
        chk("rst_rsp_valid", DW'(bus.rsp_valid), '0);
        chk("rst_rsp_data", bus.rsp_data, '0);
        chk("rst_cache_addr", DW'(bus.cache_addr), '0);
        bus.req_valid = '0;
        reset = 1'b1;

        // Single read of address 3 by client 0.
        clear_logs();
        bus.req_valid = 2'b01;
        set_addrs(6'd3, 6'd0);
        bus.rsp_ready = 2'b11;
        step();
        bus.req_valid = '0;
        repeat (5) step();
        chk("t1_hs_count", DW'(hs_cyc_q.size()), DW'(1));
        chk("t1_latency", DW'(qget(rise_cyc_q, 0) - qget(hs_cyc_q, 0)), DW'(3));
        chk("t1_data", qgetd(rise_data_q, 0), DW'(32'hA3));

        // Both clients continuously from reset: alternate, four cycles apart.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        clear_logs();
        bus.req_valid = 2'b11;
        set_addrs(6'd1, 6'd2);
        repeat (17) step();
        bus.req_valid = '0;
        repeat (5) step();
        chk("t2_grant0", DW'(qget(hs_cli_q, 0)), DW'(0));
        chk("t2_grant1", DW'(qget(hs_cli_q, 1)), DW'(1));
        chk("t2_grant2", DW'(qget(hs_cli_q, 2)), DW'(0));
        chk("t2_grant3", DW'(qget(hs_cli_q, 3)), DW'(1));
        chk("t2_spacing", DW'(qget(hs_cyc_q, 3) - qget(hs_cyc_q, 2)), DW'(4));
        chk("t2_rsp0", qgetd(rise_data_q, 0), DW'(32'hA1));
        chk("t2_rsp1", qgetd(rise_data_q, 1), DW'(32'hA2));
        chk("t2_rsp3", qgetd(rise_data_q, 3), DW'(32'hA2));

        // Cache empty blocks the grant for ten cycles.
        clear_logs();
        bus.cache_empty = 1'b1;
        bus.req_valid   = 2'b10;
        set_addrs(6'd0, 6'd7);
        repeat (10) step();
        chk("t3_blocked", DW'(hs_cyc_q.size()), DW'(0));
        bus.cache_empty = 1'b0;
        step();
        bus.req_valid = '0;
        repeat (4) step();
        chk("t3_hs_count", DW'(hs_cyc_q.size()), DW'(1));
        chk("t3_latency", DW'(qget(rise_cyc_q, 0) - qget(hs_cyc_q, 0)), DW'(3));
        chk("t3_data", qgetd(rise_data_q, 0), DW'(32'hA7));

        // Client 0 stalls its response five cycles; client 1 waits meanwhile.
        clear_logs();
        bus.req_valid = 2'b11;
        set_addrs(6'd9, 6'd10);
        bus.rsp_ready = 2'b10;
        step();
        bus.req_valid = 2'b10;
        repeat (7) step();
        chk("t4_no_grant", DW'(hs_cyc_q.size()), DW'(1));
        bus.rsp_ready = 2'b01;
        step();
        bus.rsp_ready = 2'b11;
        step();
        bus.req_valid = '0;
        repeat (5) step();
        chk("t4_order", DW'(qget(hs_cli_q, 1)), DW'(1));
        chk("t4_resume", DW'(qget(hs_cyc_q, 1) - qget(rise_cyc_q, 0)), DW'(6));
        chk("t4_data", qgetd(rise_data_q, 0), DW'(32'hA9));

        // Asynchronous reset while waiting for cache data.
        clear_logs();
        bus.req_valid        = 2'b01;
        bus.cache_data_valid = 1'b0;
        set_addrs(6'd12, 6'd13);
        step();
        bus.req_valid = '0;
        repeat (2) step();
        #2;
        reset = 1'b0;
        #1;
        chk("t5_req_ready", DW'(bus.req_ready), '0);
        chk("t5_rsp_valid", DW'(bus.rsp_valid), '0);
        chk("t5_rsp_data", bus.rsp_data, '0);
        chk("t5_cache_addr", DW'(bus.cache_addr), '0);
        bus.req_valid        = 2'b10;
        bus.cache_data_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("t5_rst_ready", DW'(bus.req_ready), '0);
        reset = 1'b1;
        model_reset();
        clear_logs();
        step();
        bus.req_valid = '0;
        repeat (5) step();
        chk("t5_first", DW'(qget(hs_cli_q, 0)), DW'(1));
        chk("t5_one_rsp", DW'(rise_cyc_q.size()), DW'(1));
        chk("t5_data", qgetd(rise_data_q, 0), DW'(32'hAD));

        // Cache data late by two cycles.
        clear_logs();
        bus.req_valid        = 2'b01;
        bus.cache_data_valid = 1'b0;
        set_addrs(6'd20, 6'd0);
        step();
        bus.req_valid = '0;
        repeat (3) step();
        bus.cache_data_valid = 1'b1;
        repeat (4) step();
        chk("t6_latency", DW'(qget(rise_cyc_q, 0) - qget(hs_cyc_q, 0)), DW'(5));
        chk("t6_data", qgetd(rise_data_q, 0), DW'(32'hB4));

        // Random traffic against the model.
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 2000; i++) begin
            bus.req_valid        = N'($urandom);
            bus.req_addr         = (N*AW)'($urandom);
            bus.rsp_ready        = N'($urandom);
            bus.cache_empty      = ($urandom_range(3) == 0);
            bus.cache_data_valid = ($urandom_range(3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_read_arbiter.md
# cache_read_arbiter

Round-robin arbiter that shares the single read port of the cache controller between `NUM_REQUESTERS` independent read clients. Each client issues an address with a valid/ready handshake. The arbiter drives the cache read address, waits out the cache's one-cycle registered read latency, then returns the data to the granting client with its own valid/ready handshake. It sits directly in front of the cache controller's `i_addr`/`o_data` port and is the only block allowed to drive that address.

## Interface
- `NUM_REQUESTERS`, 2, number of read clients (≥2)
- `C_DATA_WIDTH`, 128, cache word width (8 under `FORMAL`)
- `C_SIZE_OF_CACHE`, 64, cache depth (4 under `FORMAL`); `AW = $clog2(C_SIZE_OF_CACHE)`
- `clk`  in  1  sole clock, all logic on posedge
- `reset`  in  1  asynchronous, active-low (0 = in reset); one clock, reset asynchronous active-low
- `req_valid`  in  NUM_REQUESTERS  per-client read request valid
- `req_addr`  in  NUM_REQUESTERS*AW  packed addresses, client k at `[k*AW +: AW]`
- `req_ready`  out  NUM_REQUESTERS  per-client request accept; one-hot or zero
- `rsp_valid`  out  NUM_REQUESTERS  per-client response valid; one-hot or zero
- `rsp_data`  out  C_DATA_WIDTH  response data, shared bus, meaningful only with a `rsp_valid` bit
- `rsp_ready`  in  NUM_REQUESTERS  per-client response accept
- `cache_addr`  out  AW  to cache `i_addr`, registered
- `cache_empty`  in  1  from cache `empty`
- `cache_data`  in  C_DATA_WIDTH  from cache `o_data`
- `cache_data_valid`  in  1  from cache `o_data_is_valid`

## Operation
- FSM states: IDLE, READ, CAPT, RESP. `grant` register holds the winning client index. `last` register holds the previously served client.
- IDLE
  - If `cache_empty==0` and any `req_valid` is set, the winner is the first set `req_valid` searching `last+1, last+2, …` modulo N.
  - `req_ready[winner]=1` is driven combinationally in the same cycle, so the request handshakes that cycle.
  - At the clock edge: `cache_addr<=req_addr[winner]`, `grant<=winner`, go to READ.
  - If `cache_empty==1`, all `req_ready` are 0 and the FSM stays in IDLE.
- READ
  - `cache_addr` is held stable; the cache samples it at the end of this cycle.
  - If `cache_empty==1` at the edge, the FSM stays in READ because the cache did not update. Otherwise it goes to CAPT.
- CAPT
  - If `cache_data_valid==1`: `rsp_data<=cache_data`, `rsp_valid[grant]<=1`, go to RESP.
  - Otherwise it stays in CAPT.
- RESP
  - `rsp_valid[grant]` and `rsp_data` are held until `rsp_ready[grant]==1` at an edge.
  - On that handshake: clear `rsp_valid`, `last<=grant`, go to IDLE.
  - `rsp_ready` bits of non-granted clients are ignored.
- `req_ready` is 0 in every state except IDLE, so only one transaction is ever outstanding.
- Client index arithmetic is modulo N, wrapping N-1→0.
- Reset values (asynchronous, immediate): state IDLE, `cache_addr=0`, `rsp_data=0`, `rsp_valid=0`, `grant=0`, `last=N-1` so client 0 has first priority.
- While `reset==0`: `req_ready=0`.
- Reset asserted mid-transaction abandons it; no response is ever delivered for it.

## Timing
- Minimum latency: request handshake in cycle T; READ in T+1; CAPT in T+2; `rsp_valid` high in T+3.
- Maximum throughput: one read per 4 cycles when `rsp_ready` is held at 1. The next `req_ready` can rise in cycle T+4.
- Each cycle `cache_empty` is high in READ adds one cycle of latency. The same holds for each cycle `cache_data_valid` is low in CAPT.
- `rsp_data` and `cache_addr` never change while `rsp_valid` is high.
- A requester that drops `req_valid` before its handshake loses nothing; no state is kept for it.

## Test plan
- Single client 0 reads addr 3 with the cache filled with 0xA0+i: `req_ready[0]` is high in cycle T; `rsp_valid[0]` is high in T+3 with `rsp_data`=0xA3; `cache_addr`=3 from T+1.
- Both clients request continuously (addr 1 and addr 2) from reset: grants alternate 0,1,0,1; the responses are 0xA1, 0xA2, 0xA1, 0xA2, spaced 4 cycles apart.
- `cache_empty=1` while client 1 requests: `req_ready` stays 0 for 10 cycles. Then deassert `cache_empty`: the handshake occurs that cycle and the response arrives 3 cycles later.
- Client 0 holds `rsp_ready=0` for 5 cycles in RESP: `rsp_valid[0]` and `rsp_data` stay stable, no `req_ready` rises for client 1, and the FSM proceeds on the first `rsp_ready=1` edge.
- `reset` is pulled low asynchronously in CAPT: all outputs go to 0 immediately. After release, a pending client 1 request is served first only if client 0 is idle (`last=N-1`), and no stale response appears.
- `cache_data_valid=0` for 2 cycles in CAPT: the response is delayed by exactly 2 cycles and carries the correct data.
